// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Contents:
//   ctrl_state_t   sequencer state (RUN / STALL / MEMWAIT)
//   XZR            architectural zero register, never a real producer
//   ctrl_out_t     bundle of the five pipeline-register control outputs
//   CTRL_*         fixed control patterns (reset, bubble, freeze)
//   ctrl_run()     normal-advance pattern with optional wrong-path squash
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;
  } ctrl_out_t;

  // Reset: nothing advances, front end fed NOPs/bubbles.
  localparam ctrl_out_t CTRL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                        idex_bubble: 1'b1, pipe_freeze: 1'b0};
  // Data hazard: hold PC and IF/ID, insert one bubble into EX.
  localparam ctrl_out_t CTRL_BUBBLE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idex_bubble: 1'b1, pipe_freeze: 1'b0};
  // Memory wait: whole pipe holds, MEM/WB takes a bubble.
  localparam ctrl_out_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idex_bubble: 1'b0, pipe_freeze: 1'b1};

  // Normal advance; a taken branch squashes the word fetched behind it.
  function automatic ctrl_out_t ctrl_run(input logic flush);
    ctrl_out_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: flush,
          idex_bubble: 1'b0, pipe_freeze: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational operand-hazard comparators for the instruction in ID.
// Ports:
//   rn_id, rm_id, uses_rm_id, cbz_id   operand info of the ID instruction
//   rd_ex, load_ex                     producer in EX
//   rd_mem, load_mem                   producer in MEM
//   lu    load in EX feeds an ID source (needs 1 bubble)
//   cz1   CBZ in ID tests a register loaded by MEM (needs 1 bubble)
//   cz2   CBZ in ID tests a register loaded by EX (needs 2 bubbles)
// XZR as a destination never creates a hazard since it is never written.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rn_id,
  input  logic [4:0] rm_id,
  input  logic       uses_rm_id,
  input  logic       cbz_id,
  input  logic [4:0] rd_ex,
  input  logic       load_ex,
  input  logic [4:0] rd_mem,
  input  logic       load_mem,
  output logic       lu,
  output logic       cz1,
  output logic       cz2
);

  logic ex_live_s;
  logic mem_live_s;

  assign ex_live_s  = load_ex  & (rd_ex  != XZR);
  assign mem_live_s = load_mem & (rd_mem != XZR);

  assign lu  = ex_live_s & ((rd_ex == rn_id) | (uses_rm_id & (rd_ex == rm_id)));
  // CBZ compares in ID, so it must also wait out the load sitting in MEM.
  assign cz2 = cbz_id & ex_live_s  & (rd_ex  == rm_id);
  assign cz1 = cbz_id & mem_live_s & (rd_mem == rm_id);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rn_id..load_mem            operand/producer info for hazard detection
//   br_taken_id                branch in ID resolved taken
//   mem_req, mem_ready         MEM-stage data-memory handshake
//   pc_en, ifid_en             PC and IF/ID load enables
//   ifid_flush, idex_bubble    NOP/bubble injection into IF/ID and ID/EX
//   pipe_freeze                hold ID/EX and EX/MEM, bubble into MEM/WB
//   mem_timeout                sticky: a memory access exceeded MAX_WAIT cycles
//   stall_cycles               saturating count of cycles with pc_en low
// Control outputs are combinational: hazards must be acted on in the same
// cycle they are seen.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_id,
  input  logic [4:0]       rm_id,
  input  logic             uses_rm_id,
  input  logic             cbz_id,
  input  logic             br_taken_id,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic [4:0]       rd_mem,
  input  logic             load_mem,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned      WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  ctrl_state_t       state_r;
  ctrl_state_t       state_nxt_s;
  logic [1:0]        stall_left_r;
  logic [1:0]        stall_left_nxt_s;
  logic [1:0]        stall_reload_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              timeout_set_s;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cycles_r;
  logic              lu_s;
  logic              cz1_s;
  logic              cz2_s;
  logic              block_s;
  logic              mem_wait_s;
  logic              mem_done_s;
  ctrl_out_t         ctrl_s;

  hazard_detect u_hazard_detect (
    .rn_id      (rn_id),
    .rm_id      (rm_id),
    .uses_rm_id (uses_rm_id),
    .cbz_id     (cbz_id),
    .rd_ex      (rd_ex),
    .load_ex    (load_ex),
    .rd_mem     (rd_mem),
    .load_mem   (load_mem),
    .lu         (lu_s),
    .cz1        (cz1_s),
    .cz2        (cz2_s)
  );

  // stall_left is only non-zero in STALL, so "hazard or owed bubble" is one test.
  // Owed bubbles are consumed first; a fresh CBZ-on-EX-load owes one extra.
  assign block_s        = lu_s | cz1_s | cz2_s | (stall_left_r != 2'd0);
  assign stall_reload_s = (stall_left_r != 2'd0) ? (stall_left_r - 2'd1)
                                                  : (cz2_s ? 2'd1 : 2'd0);
  assign mem_wait_s     = mem_req & ~mem_ready;
  // A wait ends on ready or once MAX_WAIT frozen cycles have elapsed.
  assign mem_done_s     = mem_ready | (wait_cnt_r == WAIT_MAX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and counter-update logic.
  always_comb begin
    state_nxt_s      = state_r;
    stall_left_nxt_s = 2'd0;
    wait_cnt_nxt_s   = WAIT_ZERO;
    timeout_set_s    = 1'b0;
    case (state_r)
      RUN, STALL: begin
        if (mem_wait_s) begin
          // Any pending bubbles are dropped; hazards are re-detected on return.
          state_nxt_s    = MEMWAIT;
          wait_cnt_nxt_s = WAIT_ONE;
        end else if (block_s) begin
          state_nxt_s      = STALL;
          stall_left_nxt_s = stall_reload_s;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEMWAIT: begin
        if (mem_done_s) begin
          // The pipe advances this cycle, so the ID instruction is checked now.
          timeout_set_s = ~mem_ready;
          if (block_s) begin
            state_nxt_s      = STALL;
            stall_left_nxt_s = stall_reload_s;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s    = MEMWAIT;
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Pipeline control outputs.
  always_comb begin
    ctrl_s = CTRL_RESET;
    if (reset) begin
      ctrl_s = CTRL_RESET;
    end else begin
      case (state_r)
        RUN, STALL: begin
          if (mem_wait_s) begin
            ctrl_s = CTRL_FREEZE;
          end else if (block_s) begin
            // Branch outcome is untrustworthy while operands are pending.
            ctrl_s = CTRL_BUBBLE;
          end else begin
            ctrl_s = ctrl_run(br_taken_id);
          end
        end
        MEMWAIT: begin
          if (!mem_done_s) begin
            ctrl_s = CTRL_FREEZE;
          end else if (block_s) begin
            ctrl_s = CTRL_BUBBLE;
          end else begin
            // Freeze drops so MEM/WB captures the completed access.
            ctrl_s = ctrl_run(br_taken_id);
          end
        end
        default: begin
          ctrl_s = CTRL_RESET;
        end
      endcase
    end
  end

  // Bubble and memory-wait counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_left_r <= 2'd0;
      wait_cnt_r   <= WAIT_ZERO;
    end else begin
      stall_left_r <= stall_left_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
    end
  end

  // Sticky timeout flag and saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= CNT_ZERO;
    end else begin
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
      if (!ctrl_s.pc_en && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign pc_en        = ctrl_s.pc_en;
  assign ifid_en      = ctrl_s.ifid_en;
  assign ifid_flush   = ctrl_s.ifid_flush;
  assign idex_bubble  = ctrl_s.idex_bubble;
  assign pipe_freeze  = ctrl_s.pipe_freeze;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks "memory access outstanding", "cycles waited" and "bubbles owed".
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 8;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  localparam logic [4:0] E_RESET  = 5'b00110;
  localparam logic [4:0] E_BUBBLE = 5'b00010;
  localparam logic [4:0] E_FREEZE = 5'b00001;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rn_id, rm_id, rd_ex, rd_mem;
  logic             uses_rm_id, cbz_id, br_taken_id, load_ex, load_mem;
  logic             mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [4:0]       dut_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  // model state (current) and its value after the next clock edge
  bit   m_waiting = 0, n_waiting;
  int   m_waited  = 0, n_waited;
  int   m_owed    = 0, n_owed;
  bit   m_tmo     = 0, n_tmo;
  int   m_cnt     = 0, n_cnt;
  logic [4:0] e_ctrl;

  int   base;
  bit   mg_active = 0;
  int   mg_lat    = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .rn_id(rn_id), .rm_id(rm_id), .uses_rm_id(uses_rm_id), .cbz_id(cbz_id),
    .br_taken_id(br_taken_id), .rd_ex(rd_ex), .load_ex(load_ex),
    .rd_mem(rd_mem), .load_mem(load_mem), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  assign dut_ctrl = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    rn_id = 5'd0; rm_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
    uses_rm_id = 1'b0; cbz_id = 1'b0; br_taken_id = 1'b0;
    load_ex = 1'b0; load_mem = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Expected outputs for this cycle and model state after the coming edge.
  task automatic model_eval();
    bit lu, c1, c2, hz, eval_hz;
    if (reset) begin
      m_waiting = 0; m_waited = 0; m_owed = 0; m_tmo = 0; m_cnt = 0;
      n_waiting = 0; n_waited = 0; n_owed = 0; n_tmo = 0; n_cnt = 0;
      e_ctrl = E_RESET;
    end else begin
      lu = load_ex && rd_ex != 5'd31 &&
           (rd_ex == rn_id || (uses_rm_id && rd_ex == rm_id));
      c2 = cbz_id && load_ex  && rd_ex  == rm_id && rd_ex  != 5'd31;
      c1 = cbz_id && load_mem && rd_mem == rm_id && rd_mem != 5'd31;
      hz = lu || c1 || c2;
      n_waiting = m_waiting; n_waited = m_waited; n_owed = m_owed; n_tmo = m_tmo;
      eval_hz = 1;
      e_ctrl = E_RESET;
      if (!m_waiting) begin
        if (mem_req && !mem_ready) begin
          e_ctrl = E_FREEZE; n_waiting = 1; n_waited = 1; n_owed = 0; eval_hz = 0;
        end
      end else if (mem_ready || m_waited == MAX_WAIT) begin
        if (!mem_ready) n_tmo = 1;
        n_waiting = 0;
      end else begin
        e_ctrl = E_FREEZE; n_waited = m_waited + 1; eval_hz = 0;
      end
      if (eval_hz) begin
        if (hz || m_owed > 0) begin
          e_ctrl = E_BUBBLE;
          n_owed = (m_owed > 0) ? m_owed - 1 : (c2 ? 1 : 0);
        end else begin
          e_ctrl = {1'b1, 1'b1, br_taken_id, 1'b0, 1'b0};
          n_owed = 0;
        end
      end
      n_cnt = (!e_ctrl[4] && m_cnt < CNT_SAT) ? m_cnt + 1 : m_cnt;
    end
  endtask

  // Inputs already driven just after the previous edge; sample mid-cycle.
  task automatic step();
    #4;
    model_eval();
    chk("ctrl", 32'(dut_ctrl), 32'(e_ctrl));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  endtask

  task automatic adv();
    @(posedge clk);
    m_waiting = n_waiting; m_waited = n_waited; m_owed = n_owed;
    m_tmo = n_tmo; m_cnt = n_cnt;
    #1;
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd4;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk); #1;
    step(); chk("rst_pc_en", 32'(pc_en), 32'd0); chk("rst_flush", 32'(ifid_flush), 32'd1);
    adv();
    reset = 1'b0;
    step(); chk("post_rst_run", 32'(pc_en), 32'd1); adv();

    // LDUR X1 in EX, ADD X2,X1,X3 in ID
    base = m_cnt;
    load_ex = 1'b1; rd_ex = 5'd1; rn_id = 5'd1; rm_id = 5'd3; uses_rm_id = 1'b1;
    step(); chk("lu_bubble", 32'(idex_bubble), 32'd1); chk("lu_pc", 32'(pc_en), 32'd0); adv();
    load_ex = 1'b0; rd_ex = 5'd0; load_mem = 1'b1; rd_mem = 5'd1;
    step(); chk("lu_resume", 32'(pc_en), 32'd1); adv();
    chk("lu_cnt", 32'(stall_cycles), 32'(base + 1));
    clr();

    // LDUR X31 in EX, ID reads X31
    load_ex = 1'b1; rd_ex = 5'd31; rn_id = 5'd31; rm_id = 5'd31; uses_rm_id = 1'b1; cbz_id = 1'b1;
    step(); chk("xzr_pc", 32'(pc_en), 32'd1); adv();
    clr();

    // LDUR X4 in EX, CBZ X4 in ID, branch would be taken
    load_ex = 1'b1; rd_ex = 5'd4; rm_id = 5'd4; cbz_id = 1'b1; uses_rm_id = 1'b1; br_taken_id = 1'b1;
    step(); chk("cbz_b1", 32'(idex_bubble), 32'd1); chk("cbz_fl1", 32'(ifid_flush), 32'd0); adv();
    load_ex = 1'b0; rd_ex = 5'd0; load_mem = 1'b1; rd_mem = 5'd4;
    step(); chk("cbz_b2", 32'(idex_bubble), 32'd1); chk("cbz_fl2", 32'(ifid_flush), 32'd0); adv();
    load_mem = 1'b0; rd_mem = 5'd0;
    step(); chk("cbz_go", 32'(pc_en), 32'd1); chk("cbz_fl3", 32'(ifid_flush), 32'd1); adv();
    clr();

    // taken branch, no hazard
    br_taken_id = 1'b1;
    step(); chk("br_flush", 32'(ifid_flush), 32'd1); chk("br_pc", 32'(pc_en), 32'd1); adv();
    clr();
    step(); chk("br_one", 32'(ifid_flush), 32'd0); adv();

    // single-cycle memory
    mem_req = 1'b1; mem_ready = 1'b1;
    step(); chk("mem1_frz", 32'(pipe_freeze), 32'd0); chk("mem1_pc", 32'(pc_en), 32'd1); adv();
    clr();

    // memory ready after 5 cycles
    base = m_cnt;
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk("mem5_frz", 32'(pipe_freeze), 32'd1); adv();
    end
    mem_ready = 1'b1;
    step(); chk("mem5_rel", 32'(pipe_freeze), 32'd0); chk("mem5_pc", 32'(pc_en), 32'd1); adv();
    clr();
    chk("mem5_cnt", 32'(stall_cycles), 32'(base + 5));

    // memory never ready: timeout after MAX_WAIT frozen cycles
    mem_req = 1'b1;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      step(); chk("tmo_frz", 32'(pipe_freeze), (i < MAX_WAIT) ? 32'd1 : 32'd0); adv();
    end
    clr();
    step(); chk("tmo_set", 32'(mem_timeout), 32'd1); adv();
    step(); chk("tmo_sticky", 32'(mem_timeout), 32'd1); adv();

    // reset in the middle of a wait
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); adv();
    end
    reset = 1'b1;
    step();
    chk("rst_tmo", 32'(mem_timeout), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_frz", 32'(pipe_freeze), 32'd0);
    adv();
    reset = 1'b0; clr();
    step(); chk("rst_run", 32'(pc_en), 32'd1); adv();

    // randomized traffic with a latency-driven memory
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 149) == 0);
      rn_id       = pick();
      rm_id       = pick();
      rd_ex       = pick();
      rd_mem      = pick();
      uses_rm_id  = $urandom_range(0, 1) == 1;
      cbz_id      = $urandom_range(0, 3) == 0;
      br_taken_id = $urandom_range(0, 2) == 0;
      load_ex     = $urandom_range(0, 2) == 0;
      load_mem    = $urandom_range(0, 2) == 0;
      if (!mg_active && $urandom_range(0, 7) == 0) begin
        mg_active = 1;
        mg_lat    = $urandom_range(0, 11);
      end
      mem_req   = mg_active;
      mem_ready = mg_active && (mg_lat == 0);
      step();
      adv();
      if (mg_active) begin
        if (mg_lat == 0) mg_active = 0;
        else mg_lat--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
